// File: rtl/gpu_instruction_writer.sv
// Host-side producer for the GPU instruction FIFO pair.
// Queues {A,B} words and pushes them with a 3-cycle write handshake.
module gpu_instruction_writer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_wr_en,
  input  logic [31:0]                  in_dataA,
  input  logic [31:0]                  in_dataB,
  input  logic                         in_clear_overflow,
  input  logic                         wrfull,
  output logic [31:0]                  out_dataA,
  output logic [31:0]                  out_dataB,
  output logic                         out_wrreq,
  output logic                         out_full,
  output logic                         out_idle,
  output logic                         out_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   out_pending,
  output logic [CNT_W-1:0]             out_sent_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SETTLE
  } state_t;

  state_t state;
  state_t state_next;

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             drop;
  logic             pop;
  logic             load;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees space.
  always_comb begin
    push = in_wr_en && (count != FULL_CNT);
    drop = in_wr_en && (count == FULL_CNT);
    pop  = (state == WRITE);
  end

  // Next-state: latch the head when the FIFO has room, then write, then settle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && !wrfull) begin
          load       = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE:   state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_dataA, in_dataB};
  end

  // Presented words hold their value until the next head is latched.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_dataA <= '0;
      out_dataB <= '0;
    end else if (load) begin
      {out_dataA, out_dataB} <= mem[rd_ptr];
    end
  end

  // Sent counter, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset)    out_sent_count <= '0;
    else if (pop) out_sent_count <= out_sent_count + 1'b1;
  end

  // Sticky overflow; a drop wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (reset)                  out_overflow <= 1'b0;
    else if (drop)              out_overflow <= 1'b1;
    else if (in_clear_overflow) out_overflow <= 1'b0;
  end

  assign out_wrreq   = (state == WRITE);
  assign out_pending = count;
  assign out_full    = (count == FULL_CNT);
  assign out_idle    = (count == '0) && (state == IDLE);

endmodule
